// File: rtl/cpu_io_pkg.sv
// Shared constants and helpers for the CPU external I/O ports.
package cpu_io_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int DEPTH_DEF      = 4;

    // Value the holding register takes after reset.
    localparam logic [DATA_WIDTH_DEF-1:0] INIT_DEF = 32'h0;

    // Occupancy counter width: must be able to represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with push/pop strobes and empty/full flags.
// Push is ignored when full and pop is ignored when empty, so callers may
// strobe freely. Storage is not reset; only pointers and count are.
module io_sync_fifo
    import cpu_io_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty,
    output logic                  full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q,  count_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Next pointers and count; pointer width makes wrap modulo DEPTH implicit.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Pointer and count registers with synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; suppressed during clear so a reset edge never pushes.
    always_ff @(posedge clock) begin
        if (clear_n && push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/input_port_buffer.sv
// CPU input port: external valid/ready producer feeds a FIFO; each CPU "in"
// read strobe pops the head word into a holding register driving the bus mux.
// A read with nothing queued leaves the holding register alone and raises a
// sticky underflow flag. There is no bypass from ext_data to BusMuxIn.
module input_port_buffer
    import cpu_io_pkg::*;
#(
    parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int                    DEPTH      = DEPTH_DEF,
    parameter logic [DATA_WIDTH-1:0] INIT       = INIT_DEF
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic [DATA_WIDTH-1:0] ext_data,
    input  logic                  ext_valid,
    output logic                  ext_ready,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] BusMuxIn,
    output logic                  data_avail,
    output logic                  full,
    output logic                  underflow,
    input  logic                  clr_status
);

    logic                  fifo_empty;
    logic                  fifo_full;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  underflow_q, underflow_d;

    // ext_ready depends only on registered occupancy, never on ext_valid/read_en.
    assign ext_ready  = !fifo_full;
    assign data_avail = !fifo_empty;
    assign full       = fifo_full;
    assign push       = ext_valid && ext_ready;
    assign pop        = read_en && data_avail;
    assign BusMuxIn   = hold_q;
    assign underflow  = underflow_q;

    io_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .clear_n (clear_n),
        .push    (push),
        .wdata   (ext_data),
        .pop     (pop),
        .rdata   (fifo_rdata),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Holding register loads on a successful pop; underflow set beats clear.
    always_comb begin
        hold_d      = hold_q;
        underflow_d = underflow_q;
        if (pop) begin
            hold_d = fifo_rdata;
        end
        if (read_en && !data_avail) begin
            underflow_d = 1'b1;
        end else if (clr_status) begin
            underflow_d = 1'b0;
        end
    end

    // Holding register and sticky status with synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            hold_q      <= INIT;
            underflow_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: doc/input_port_buffer.md
Name: input_port_buffer

Overview:
- Receive-side counterpart of the CPU's external output port. It accepts words from an external device over a valid/ready handshake and queues them in a small FIFO.
- Each CPU "in" read strobe pops the next word into a holding register that drives the datapath bus-mux input.
- Status outputs give the control unit and software an empty/full/underflow view of the port.

Parameters:
- DATA_WIDTH, 32, width of external data, FIFO entries and bus word
- DEPTH, 4, FIFO entries; power of two, minimum 2
- INIT, 32'h0, value of holding register after reset

Ports:
- clock  input  1  system clock, all state updates on rising edge
- clear_n  input  1  synchronous active-low reset, sampled on rising clock edge
- ext_data  input  DATA_WIDTH  word offered by external device
- ext_valid  input  1  external device offers ext_data this cycle
- ext_ready  output  1  port can accept a word this cycle
- read_en  input  1  CPU "in" read strobe from control unit
- BusMuxIn  output  DATA_WIDTH  holding register value, to bus multiplexer
- data_avail  output  1  FIFO non-empty
- full  output  1  FIFO holds DEPTH words
- underflow  output  1  sticky: read_en asserted while FIFO empty
- clr_status  input  1  clears underflow

Behaviour:
- Reset (clear_n=0 at edge):
  - count=0; read and write pointers=0; holding register=INIT; underflow=0.
  - Outputs after reset: ext_ready=1, data_avail=0, full=0, BusMuxIn=INIT.
  - Reset overrides every other input, including mid-transfer.
- Push:
  - Occurs when ext_valid and ext_ready at an edge.
  - ext_data is written at the write pointer; the pointer wraps modulo DEPTH.
  - ext_ready = !full, combinational from registered count. It has no combinational path from ext_valid or read_en.
- Pop:
  - Occurs when read_en and data_avail at an edge.
  - The holding register loads the head entry; the read pointer wraps modulo DEPTH.
  - Latency: the popped word appears on BusMuxIn the cycle after the read_en edge.
  - BusMuxIn holds that value until the next successful pop or reset.
- Empty read (read_en with count=0):
  - Holding register unchanged; underflow set to 1 at that edge.
- Push to pop latency:
  - A word pushed at edge N is poppable by a read_en at edge N+1 or later.
  - No bypass: a read_en at edge N with an empty FIFO underflows even if a push occurs at the same edge.
- Simultaneous push and pop with count>0:
  - Both occur; count unchanged.
  - If full, ext_ready=0, so no push occurs; pop only.
- Count arithmetic:
  - Width clog2(DEPTH)+1.
  - count_next = count + push - pop, never outside 0..DEPTH.
- Status signals:
  - data_avail = (count!=0); full = (count==DEPTH).
  - underflow is sticky. clr_status clears it.
  - If clr_status and a new underflow occur at the same edge, set wins.
- Backpressure: ext_valid while full is not accepted. The device must hold the word until ext_ready, so no data is lost.
- Memory: FIFO storage is not reset; only pointers and count are reset.

Decomposition:
- Shared package (cpu_io_pkg):
  - default DATA_WIDTH and DEPTH constants
  - INIT reset constant
  - count-width function (clog2 based)
- Natural sub-module: io_sync_fifo.
  - Contains storage, pointers, count and full/empty.
  - Push and pop interface, same clock and clear_n.
- The top level adds the holding register, the underflow flag and the handshake glue. The output-port side can later reuse io_sync_fifo.

Test Plan:
- Reset with clear_n=0 for 2 cycles -> BusMuxIn=32'h0, ext_ready=1, data_avail=0, full=0, underflow=0.
- Push 32'hA5A5_0001, idle 1 cycle, pulse read_en -> BusMuxIn=32'hA5A5_0001 one cycle after the read edge; data_avail=0 afterwards.
- Push 5 words 1..5 continuously with DEPTH=4:
  - ext_ready drops after word 4 and full=1; word 5 is held by the device.
  - After one read_en, BusMuxIn=1, word 5 is accepted, and later reads return 2,3,4,5 in order.
- Read on empty FIFO -> underflow=1 and BusMuxIn unchanged; pulse clr_status -> underflow=0; read_en and clr_status together on empty -> underflow stays 1.
- With count=2, assert ext_valid and read_en on the same edge for 6 cycles -> count stays 2 and data order is preserved across pointer wrap-around.
- Load 3 words, then assert clear_n=0 mid-stream with ext_valid and read_en high -> count=0 and BusMuxIn=INIT; no pop or push occurs at the reset edge.
